bmlp_compute_unit: RTL and testbench
====================================

Name: bmlp_compute_unit

Overview:
- Datapath of the binary-MLP accelerator.
- Takes 9-bit input features from data memory and 1-bit weights from weight memory, one of each per cycle.
- Accumulates signed weighted sums in a 15-bit accumulator and binarises each finished neuron into an on-chip activation register file.
- Produces the final binary class; sequenced entirely by the external controller.

Parameters:
ACC_W, 15, accumulator width (signed, two's complement)
RF_DEPTH, 128, activation entries per register-file bank (7-bit address)
LAST_LAYER, 3, index of the output layer driving bin_class

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-low
layer  in  3  current layer: 0 = idle, 1 = input layer, 2..LAST_LAYER = binary layers, others = idle
g_reg_rst7  in  1  synchronous accumulator clear (start of new neuron)
rf_wen  in  1  write current neuron activation into RF
rf_ren  in  1  RF read enable
rf_waddr  in  7  RF write address
rf_raddr  in  7  RF read address
d9  in  9  input feature, signed two's complement
w  in  1  weight bit: 1 = +1, 0 = -1
bin_class  out  1  classification result (final-layer neuron activation)
rf_d1  out  1  registered RF read data
tb_gated_reg_q  out  15  accumulator contents (debug/observation)

Behaviour:
- Reset is asynchronous and active-low on rst, with one clock clk.
- While rst=0, all of the following are cleared to 0:
  - accumulator
  - rf_d1
  - bin_class
  - every RF bit in both banks
- Accumulation term (combinational):
  - layer=1: term = w ? sext(d9) : -sext(d9); range -256..+256.
  - layer 2..LAST_LAYER: term = (rf_d1 XNOR w) ? +1 : -1.
- Accumulator update on each rising edge:
  - layer idle (0 or >LAST_LAYER): acc holds (register clock-gated / enable-gated).
  - else if g_reg_rst7=1: acc <= 0. The term is discarded that cycle.
  - else acc <= sat(acc + term). Saturation bounds are [-16384, +16383]; there is no wrap-around.
- tb_gated_reg_q = acc (register output, no extra latency).
- Activation: act = (acc >= 0), i.e. ~acc[14], evaluated from the current register value.
- Register file: two banks of RF_DEPTH x 1 bit.
  - Write bank = layer[0]; read bank = ~layer[0]. Layer 1 writes bank 1; layer 2 reads bank 1 and writes bank 0; layer 3 reads bank 0 and writes bank 1.
  - Write: on an edge with rf_wen=1 and layer non-idle, rf[wbank][rf_waddr] <= act.
  - Writes in idle layers are ignored.
  - Read: on an edge with rf_ren=1, rf_d1 <= rf[rbank][rf_raddr]; otherwise rf_d1 holds. Latency is 1 cycle, so the controller presents raddr one cycle before the weight that pairs with it.
  - Read and write of the same bank/address in one cycle returns the old value. This cannot occur with correct banking but must be deterministic.
- bin_class: on an edge with rf_wen=1 and layer==LAST_LAYER, bin_class <= act. Otherwise it holds.
- Simultaneous rf_wen and g_reg_rst7: RF and bin_class capture act from the pre-clear accumulator; acc clears on the same edge. This is the normal neuron-boundary case.
- Reset asserted mid-layer: everything clears immediately, and resumption requires the controller to restart from layer 1.

Test Plan:
- Reset:
  - Stimulus: hold rst=0 for 10 ns, then release with layer=0.
  - Expected: tb_gated_reg_q=0, rf_d1=0, bin_class=0, and acc stays 0 over 5 idle cycles despite w/d9 toggling.
- Layer-1 accumulate:
  - Stimulus: layer=1, one clear cycle, then (d9=100,w=1), (d9=30,w=0), (d9=-5,w=1).
  - Expected: acc=65. Then rf_wen with rf_waddr=7 writes 1 to bank1[7].
  - Follow-up: a next neuron with (d9=10,w=0) gives acc=-10; rf_wen with rf_waddr=8 writes 0.
- Saturation:
  - Stimulus: layer=1, d9=255, w=1 for 70 cycles.
  - Expected: acc stops at 16383.
  - Stimulus: d9=-256, w=1 for 70 cycles from clear.
  - Expected: acc stops at -16384.
- Binary layer XNOR and read latency:
  - Stimulus: preload bank1[0..3]=1,0,1,1 via layer 1. At layer=2, read addresses 0..3 with weights 1,1,0,1, aligned one cycle late.
  - Expected: acc = +1-1-1+1 = 0, so act=1. rf_wen with waddr=0 writes bank0[0]=1 while bank1 stays unchanged.
- Final layer and boundary:
  - Stimulus: layer=3 with an accumulation ending at acc=-3; assert rf_wen and g_reg_rst7 together.
  - Expected: bin_class=0, bank1[waddr]=0, acc=0 next cycle.
  - Stimulus: repeat ending at acc=+2.
  - Expected: bin_class=1.
- Reset mid-run:
  - Stimulus: assert rst=0 asynchronously during layer 2 accumulation.
  - Expected: acc, rf_d1, bin_class and all RF bits read back 0 immediately (before the next edge).

Source files
------------

// File: rtl/bmlp_compute_unit_if.sv
// Controller-to-datapath bus of the binary-MLP compute unit.
// The controller (master) sequences layers, addresses and operands; the
// compute unit (slave) returns the activation read port, the class bit and
// the accumulator for observation.
interface bmlp_compute_unit_if #(
    parameter int ACC_W = 15,
    parameter int RF_AW = 7
);
    logic [2:0]       layer;
    logic             g_reg_rst7;
    logic             rf_wen;
    logic             rf_ren;
    logic [RF_AW-1:0] rf_waddr;
    logic [RF_AW-1:0] rf_raddr;
    logic [8:0]       d9;
    logic             w;
    logic             bin_class;
    logic             rf_d1;
    logic [ACC_W-1:0] tb_gated_reg_q;

    modport master (
        output layer, g_reg_rst7, rf_wen, rf_ren, rf_waddr, rf_raddr, d9, w,
        input  bin_class, rf_d1, tb_gated_reg_q
    );

    modport slave (
        input  layer, g_reg_rst7, rf_wen, rf_ren, rf_waddr, rf_raddr, d9, w,
        output bin_class, rf_d1, tb_gated_reg_q
    );
endinterface

// File: rtl/bmlp_compute_unit.sv
// Binary-MLP compute datapath: saturating signed accumulator, binarisation
// of each finished neuron into a ping-pong activation register file, and the
// final class bit. All sequencing comes from the external controller.
module bmlp_compute_unit #(
    parameter int ACC_W      = 15,
    parameter int RF_DEPTH   = 128,
    parameter int LAST_LAYER = 3
) (
    input  logic                 clk,
    input  logic                 rst,   // asynchronous, active-low
    bmlp_compute_unit_if.slave   bus
);
    localparam logic [2:0] LAST_L = 3'(LAST_LAYER);

    // Saturation bounds expressed one bit wider than the accumulator so the
    // raw sum can be compared before it is narrowed.
    localparam logic signed [ACC_W:0] SAT_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {2'b11, {(ACC_W-1){1'b0}}};

    logic                    w_active;
    logic                    w_act;
    logic                    w_wbank;
    logic                    w_rbank;
    logic signed [ACC_W-1:0] w_feat;
    logic signed [ACC_W-1:0] w_term;
    logic signed [ACC_W:0]   w_sum;
    logic signed [ACC_W-1:0] w_acc_next;

    logic signed [ACC_W-1:0] r_acc;
    logic [RF_DEPTH-1:0]     r_rf [2];
    logic                    r_rf_d1;
    logic                    r_bin_class;

    // Layers 0 and anything past the output layer leave the datapath frozen.
    assign w_active = (bus.layer != 3'd0) && (bus.layer <= LAST_L);
    // Non-negative accumulator binarises to 1.
    assign w_act    = ~r_acc[ACC_W-1];
    // Odd layers write bank 1 and read bank 0; even layers the reverse.
    assign w_wbank  = bus.layer[0];
    assign w_rbank  = ~bus.layer[0];
    assign w_feat   = {{(ACC_W-9){bus.d9[8]}}, bus.d9};

    // Select the signed term for this cycle and form the saturated sum.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        w_term     = '0;
        w_acc_next = r_acc;
        if (bus.layer == 3'd1) begin
            w_term = bus.w ? w_feat : -w_feat;
        end else begin
            w_term = (bus.rf_d1 ~^ bus.w) ? {{(ACC_W-1){1'b0}}, 1'b1} : '1;
        end
        w_sum = {r_acc[ACC_W-1], r_acc} + {w_term[ACC_W-1], w_term};
        if (w_sum > SAT_MAX) begin
            w_acc_next = SAT_MAX[ACC_W-1:0];
        end else if (w_sum < SAT_MIN) begin
            w_acc_next = SAT_MIN[ACC_W-1:0];
        end else begin
            w_acc_next = w_sum[ACC_W-1:0];
        end
    end

    // Accumulator: held in idle layers, cleared at neuron start, else summed.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values of the others, independent of order.
        if (!rst) begin
            r_acc <= '0;
        end else if (w_active) begin
            r_acc <= bus.g_reg_rst7 ? '0 : w_acc_next;
        end
    end

    // Activation register file: capture the current neuron's binary output.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: the activation store is built from flops with a full reset so
        // a reset mid-layer leaves no stale activations from the old run.
        if (!rst) begin
            for (int b = 0; b < 2; b++) begin
                r_rf[b] <= '0;
            end
        end else if (bus.rf_wen && w_active) begin
            r_rf[w_wbank][bus.rf_waddr] <= w_act;
        end
    end

    // Registered RF read port; a same-cycle write to the same cell returns old data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rf_d1 <= 1'b0;
        end else if (bus.rf_ren) begin
            r_rf_d1 <= r_rf[w_rbank][bus.rf_raddr];
        end
    end

    // Class bit: the output layer's neuron activation, captured on its write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_bin_class <= 1'b0;
        end else if (bus.rf_wen && (bus.layer == LAST_L)) begin
            r_bin_class <= w_act;
        end
    end

    assign bus.tb_gated_reg_q = r_acc;
    assign bus.rf_d1          = r_rf_d1;
    assign bus.bin_class      = r_bin_class;

endmodule

// File: tb/tb_bmlp_compute_unit.sv
// Self-checking bench for bmlp_compute_unit: directed vector table,
// multi-cycle corner sequences and randomized cycles against a model.
module tb_bmlp_compute_unit;
    localparam int ACC_MAX = 16383;
    localparam int ACC_MIN = -16384;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bmlp_compute_unit_if bus ();

    bmlp_compute_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state: accumulator as a plain integer, RF as bit arrays.
    int m_acc;
    bit m_rf [2][128];
    bit m_rf_d1;
    bit m_bin;

    typedef struct {
        int layer;
        bit clr;
        bit wen;
        int waddr;
        bit ren;
        int raddr;
        int d9;
        bit w;
        int exp_acc;
        bit exp_rf_d1;
        bit exp_bin;
    } vec_t;

    vec_t tbl [16];

    task automatic check(input string name, input logic signed [31:0] actual,
                         input logic signed [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_acc   = 0;
        m_rf_d1 = 1'b0;
        m_bin   = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 128; a++)
                m_rf[b][a] = 1'b0;
    endtask

    // One clock of the datapath, computed from the rules with integers.
    task automatic model_step(input int l, input bit clr, input bit wen, input int wa,
                              input bit ren, input int ra, input int d, input bit wt);
        bit active;
        bit act;
        bit rd;
        int term;
        int sum;
        active = (l >= 1) && (l <= 3);
        act    = (m_acc >= 0);
        if (l == 1) term = wt ? d : -d;
        else        term = (m_rf_d1 == wt) ? 1 : -1;
        rd = m_rf[(l % 2 == 0) ? 1 : 0][ra];
        if (wen && active) m_rf[l % 2][wa] = act;
        if (ren) m_rf_d1 = rd;
        if (wen && l == 3) m_bin = act;
        if (active) begin
            sum = m_acc + term;
            if (sum > ACC_MAX) sum = ACC_MAX;
            if (sum < ACC_MIN) sum = ACC_MIN;
            m_acc = clr ? 0 : sum;
        end
    endtask

    // Drive one cycle of inputs, clock it, advance the model, settle.
    task automatic apply(input int l, input bit clr, input bit wen, input int wa,
                         input bit ren, input int ra, input int d, input bit wt);
        bus.layer      = 3'(l);
        bus.g_reg_rst7 = clr;
        bus.rf_wen     = wen;
        bus.rf_waddr   = 7'(wa);
        bus.rf_ren     = ren;
        bus.rf_raddr   = 7'(ra);
        bus.d9         = 9'(d);
        bus.w          = wt;
        @(posedge clk);
        model_step(l, clr, wen, wa, ren, ra, d, wt);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " acc"}, $signed(bus.tb_gated_reg_q), m_acc);
        check({tag, " rf_d1"}, {31'b0, bus.rf_d1}, {31'b0, m_rf_d1});
        check({tag, " bin_class"}, {31'b0, bus.bin_class}, {31'b0, m_bin});
    endtask

    initial begin
        bit pre [4];
        bit wts [4];
        int run_exp [4];
        int l;
        int r;

        // Directed vectors, starting from the post-reset state.
        tbl[0]  = '{1, 1, 0, 0, 0, 0,    0, 0,   0, 0, 0};
        tbl[1]  = '{1, 0, 0, 0, 0, 0,  100, 1, 100, 0, 0};
        tbl[2]  = '{1, 0, 0, 0, 0, 0,   30, 0,  70, 0, 0};
        tbl[3]  = '{1, 0, 0, 0, 0, 0,   -5, 1,  65, 0, 0};
        tbl[4]  = '{1, 1, 1, 7, 0, 0,   99, 1,   0, 0, 0};
        tbl[5]  = '{1, 0, 0, 0, 0, 0,   10, 0, -10, 0, 0};
        tbl[6]  = '{1, 1, 1, 8, 0, 0,    0, 0,   0, 0, 0};
        tbl[7]  = '{0, 0, 0, 0, 1, 7,    0, 0,   0, 1, 0};
        tbl[8]  = '{0, 0, 0, 0, 1, 8,    0, 0,   0, 0, 0};
        tbl[9]  = '{0, 0, 0, 0, 1, 7,    0, 0,   0, 1, 0};
        tbl[10] = '{0, 0, 0, 0, 0, 8,    0, 0,   0, 1, 0};
        tbl[11] = '{1, 0, 0, 0, 0, 0,   50, 1,  50, 1, 0};
        tbl[12] = '{0, 0, 0, 0, 0, 0,  100, 1,  50, 1, 0};
        tbl[13] = '{4, 0, 0, 0, 0, 0,  -20, 0,  50, 1, 0};
        tbl[14] = '{7, 0, 1, 9, 0, 0,   33, 1,  50, 1, 0};
        tbl[15] = '{0, 0, 0, 0, 1, 9,    0, 0,  50, 0, 0};

        // Reset and idle hold.
        rst = 1'b0;
        bus.layer = 3'd0; bus.g_reg_rst7 = 1'b0; bus.rf_wen = 1'b0; bus.rf_ren = 1'b0;
        bus.rf_waddr = '0; bus.rf_raddr = '0; bus.d9 = '0; bus.w = 1'b0;
        model_reset();
        #12;
        check("reset acc", $signed(bus.tb_gated_reg_q), 0);
        check("reset rf_d1", {31'b0, bus.rf_d1}, 0);
        check("reset bin_class", {31'b0, bus.bin_class}, 0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            apply(0, 0, 0, 0, 0, 0, i * 37 - 90, 1'(i));
            check("idle acc hold", $signed(bus.tb_gated_reg_q), 0);
        end

        // Vector table.
        for (int i = 0; i < 16; i++) begin
            apply(tbl[i].layer, tbl[i].clr, tbl[i].wen, tbl[i].waddr,
                  tbl[i].ren, tbl[i].raddr, tbl[i].d9, tbl[i].w);
            check($sformatf("vec%0d acc", i), $signed(bus.tb_gated_reg_q), tbl[i].exp_acc);
            check($sformatf("vec%0d rf_d1", i), {31'b0, bus.rf_d1}, {31'b0, tbl[i].exp_rf_d1});
            check($sformatf("vec%0d bin", i), {31'b0, bus.bin_class}, {31'b0, tbl[i].exp_bin});
        end

        // Positive and negative saturation.
        apply(1, 1, 0, 0, 0, 0, 0, 0);
        repeat (64) apply(1, 0, 0, 0, 0, 0, 255, 1);
        check("sat pos pre", $signed(bus.tb_gated_reg_q), 16320);
        repeat (6) apply(1, 0, 0, 0, 0, 0, 255, 1);
        check("sat pos", $signed(bus.tb_gated_reg_q), ACC_MAX);
        apply(1, 0, 0, 0, 0, 0, 255, 0);
        check("sat pos leave", $signed(bus.tb_gated_reg_q), 16128);
        apply(1, 1, 0, 0, 0, 0, 0, 0);
        repeat (70) apply(1, 0, 0, 0, 0, 0, -256, 1);
        check("sat neg", $signed(bus.tb_gated_reg_q), ACC_MIN);
        apply(1, 0, 0, 0, 0, 0, -256, 0);
        check("sat neg leave", $signed(bus.tb_gated_reg_q), -16128);

        // Binary layer: preload bank1[0..3], then XNOR with aligned weights.
        pre = '{1, 0, 1, 1};
        wts = '{1, 1, 0, 1};
        run_exp = '{1, 0, -1, 0};
        apply(1, 1, 0, 0, 0, 0, 0, 0);
        for (int a = 0; a < 4; a++) begin
            apply(1, 0, 0, 0, 0, 0, pre[a] ? 5 : -5, 1);
            apply(1, 1, 1, a, 0, 0, 0, 0);
        end
        apply(2, 1, 0, 0, 1, 0, 0, 0);
        check("l2 first read", {31'b0, bus.rf_d1}, 1);
        for (int i = 0; i < 4; i++) begin
            apply(2, 0, 0, 0, i < 3, i + 1, 0, wts[i]);
            check($sformatf("l2 acc step%0d", i), $signed(bus.tb_gated_reg_q), run_exp[i]);
        end
        apply(2, 1, 1, 0, 0, 0, 0, 0);
        check("l2 boundary acc", $signed(bus.tb_gated_reg_q), 0);
        check("l2 wen no bin", {31'b0, bus.bin_class}, 0);
        apply(5, 0, 0, 0, 1, 0, 0, 0);
        check("bank0[0]", {31'b0, bus.rf_d1}, 1);
        apply(5, 0, 0, 0, 1, 1, 0, 0);
        check("bank0[1]", {31'b0, bus.rf_d1}, 0);
        for (int a = 0; a < 4; a++) begin
            apply(0, 0, 0, 0, 1, a, 0, 0);
            check($sformatf("bank1[%0d] kept", a), {31'b0, bus.rf_d1}, {31'b0, pre[a]});
        end

        // Output layer with simultaneous write and clear.
        apply(3, 1, 0, 0, 1, 0, 0, 0);
        check("l3 read bank0", {31'b0, bus.rf_d1}, 1);
        repeat (3) apply(3, 0, 0, 0, 0, 0, 0, 0);
        check("l3 acc -3", $signed(bus.tb_gated_reg_q), -3);
        apply(3, 1, 1, 7, 0, 0, 0, 0);
        check("l3 bin neg", {31'b0, bus.bin_class}, 0);
        check("l3 clear acc", $signed(bus.tb_gated_reg_q), 0);
        repeat (2) apply(3, 0, 0, 0, 0, 0, 0, 1);
        check("l3 acc +2", $signed(bus.tb_gated_reg_q), 2);
        apply(3, 1, 1, 8, 0, 0, 0, 0);
        check("l3 bin pos", {31'b0, bus.bin_class}, 1);
        check("l3 clear acc 2", $signed(bus.tb_gated_reg_q), 0);
        apply(0, 0, 0, 0, 1, 7, 0, 0);
        check("bank1[7] neg", {31'b0, bus.rf_d1}, 0);
        apply(0, 0, 0, 0, 1, 8, 0, 0);
        check("bank1[8] pos", {31'b0, bus.rf_d1}, 1);
        check("bin hold idle", {31'b0, bus.bin_class}, 1);

        // Randomized cycles against the model.
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 3)      l = 1;
            else if (r < 6) l = 2;
            else if (r < 8) l = 3;
            else            l = int'($urandom_range(0, 7));
            apply(l, $urandom_range(0, 15) == 0, $urandom_range(0, 5) == 0,
                  int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 511)) - 256,
                  1'($urandom_range(0, 1)));
            check_model($sformatf("rand%0d", i));
        end

        // Asynchronous reset during a layer-2 accumulation.
        apply(1, 1, 0, 0, 0, 0, 0, 0);
        apply(1, 0, 0, 0, 0, 0, 5, 1);
        apply(1, 1, 1, 5, 0, 0, 0, 0);
        apply(3, 1, 1, 0, 0, 0, 0, 0);
        apply(2, 1, 0, 0, 1, 5, 0, 0);
        apply(2, 0, 0, 0, 0, 0, 0, 1);
        apply(2, 0, 0, 0, 0, 0, 0, 1);
        check("pre-rst acc", $signed(bus.tb_gated_reg_q), 2);
        check("pre-rst rf_d1", {31'b0, bus.rf_d1}, 1);
        check("pre-rst bin", {31'b0, bus.bin_class}, 1);
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check("midrst acc", $signed(bus.tb_gated_reg_q), 0);
        check("midrst rf_d1", {31'b0, bus.rf_d1}, 0);
        check("midrst bin", {31'b0, bus.bin_class}, 0);
        #2;
        rst = 1'b1;
        for (int a = 0; a < 128; a++) begin
            apply(0, 0, 0, 0, 1, a, 0, 0);
            check($sformatf("midrst bank1[%0d]", a), {31'b0, bus.rf_d1}, 0);
            apply(5, 0, 0, 0, 1, a, 0, 0);
            check($sformatf("midrst bank0[%0d]", a), {31'b0, bus.rf_d1}, 0);
        end
        check_model("post-rst");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
